// File: rtl/net_recv_pkt_arbiter_pkg.sv
// Shared definitions for the NET_RECV packet arbiter.
//   arb_state_e  : arbiter FSM state (idle / locked on one requester)
//   DefDataWidth : default beat data width
//   DefKeepWidth : default byte-enable width
//   id_width()   : width of a port index, never less than one bit
package net_recv_pkt_arbiter_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } arb_state_e;

  localparam int unsigned DefDataWidth = 512;
  localparam int unsigned DefKeepWidth = 64;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry AXI-stream skid register with one cycle of latency.
//   clk, rst               : clock, asynchronous active-low reset
//   in_data/keep/last/id   : incoming beat, qualified by in_valid
//   in_ready               : depends only on registered state (skid entry empty)
//   out_data/keep/last/id  : registered output beat, qualified by out_valid
//   out_ready              : downstream ready
module axis_skid_reg #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned KEEP_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [KEEP_WIDTH-1:0] in_keep,
  input  logic                  in_last,
  input  logic [ID_WIDTH-1:0]   in_id,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [KEEP_WIDTH-1:0] out_keep,
  output logic                  out_last,
  output logic [ID_WIDTH-1:0]   out_id,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned BeatWidth = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH;

  logic [BeatWidth-1:0] in_beat;
  logic [BeatWidth-1:0] out_q, out_d;
  logic [BeatWidth-1:0] skid_q, skid_d;
  logic                 out_valid_q, out_valid_d;
  logic                 skid_valid_q, skid_valid_d;
  logic                 in_fire;

  assign in_beat  = {in_data, in_keep, in_last, in_id};
  assign in_ready = ~skid_valid_q;
  assign in_fire  = in_valid & in_ready;

  assign {out_data, out_keep, out_last, out_id} = out_q;
  assign out_valid = out_valid_q;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || out_ready) begin
      // Output slot frees up: the older skid beat always goes first.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) out_d = in_beat;
      end
    end else if (in_fire) begin
      // Output stalled: park the beat that was accepted against the old ready.
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

endmodule

// File: rtl/net_recv_pkt_arbiter.sv
// Round-robin packet arbiter merging NUM_PORTS AXI-stream requesters into one
// stream towards the NET_RECV handler. A grant is held for a whole packet.
//   clk, rst                  : clock, asynchronous active-low reset
//   s_inbuf_axis_*            : per-requester streams, port i in slice i
//   m_outbuf_axis_*           : merged stream, tid = source port of the beat
//   pkt_count                 : packets forwarded downstream, wraps at 2^32
module net_recv_pkt_arbiter
  import net_recv_pkt_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 4,
  parameter int unsigned BUF_DATA_WIDTH = DefDataWidth,
  parameter int unsigned BUF_KEEP_WIDTH = DefKeepWidth
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PORTS*BUF_DATA_WIDTH-1:0] s_inbuf_axis_tdata,
  input  logic [NUM_PORTS*BUF_KEEP_WIDTH-1:0] s_inbuf_axis_tkeep,
  input  logic [NUM_PORTS-1:0]                s_inbuf_axis_tlast,
  input  logic [NUM_PORTS-1:0]                s_inbuf_axis_tvalid,
  output logic [NUM_PORTS-1:0]                s_inbuf_axis_tready,
  output logic [BUF_DATA_WIDTH-1:0]           m_outbuf_axis_tdata,
  output logic [BUF_KEEP_WIDTH-1:0]           m_outbuf_axis_tkeep,
  output logic                                m_outbuf_axis_tlast,
  output logic                                m_outbuf_axis_tvalid,
  input  logic                                m_outbuf_axis_tready,
  output logic [id_width(NUM_PORTS)-1:0]      m_outbuf_axis_tid,
  output logic [31:0]                         pkt_count
);

  localparam int unsigned IdWidth = id_width(NUM_PORTS);

  arb_state_e         state_q, state_d;
  logic [IdWidth-1:0] grant_q, grant_d;
  logic [IdWidth-1:0] rr_ptr_q, rr_ptr_d;
  logic [31:0]        pkt_count_q, pkt_count_d;

  logic [BUF_DATA_WIDTH-1:0] sel_data;
  logic [BUF_KEEP_WIDTH-1:0] sel_keep;
  logic                      sel_last;
  logic                      sel_valid;
  logic                      skid_ready;
  logic                      accept;

  // First requester at or above ptr, wrapping modulo NUM_PORTS.
  function automatic logic [IdWidth-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                 input logic [IdWidth-1:0]   ptr);
    logic [IdWidth-1:0] pick;
    logic [IdWidth-1:0] cand;
    int unsigned        idx;
    pick = ptr;
    // Walk from the farthest offset down so the nearest hit wins.
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      idx  = (32'(ptr) + 32'(i)) % NUM_PORTS;
      cand = IdWidth'(idx);
      if (req[cand]) pick = cand;
    end
    return pick;
  endfunction

  assign sel_data  = s_inbuf_axis_tdata[32'(grant_q)*BUF_DATA_WIDTH +: BUF_DATA_WIDTH];
  assign sel_keep  = s_inbuf_axis_tkeep[32'(grant_q)*BUF_KEEP_WIDTH +: BUF_KEEP_WIDTH];
  assign sel_last  = s_inbuf_axis_tlast[grant_q];
  assign sel_valid = (state_q == StLocked) & s_inbuf_axis_tvalid[grant_q];
  assign accept    = sel_valid & skid_ready;

  always_comb begin
    state_d             = state_q;
    grant_d             = grant_q;
    rr_ptr_d            = rr_ptr_q;
    s_inbuf_axis_tready = '0;
    unique case (state_q)
      StIdle: begin
        if (|s_inbuf_axis_tvalid) begin
          grant_d = rr_pick(s_inbuf_axis_tvalid, rr_ptr_q);
          state_d = StLocked;
        end
      end
      StLocked: begin
        s_inbuf_axis_tready[grant_q] = skid_ready;
        if (accept && sel_last) begin
          rr_ptr_d = (grant_q == IdWidth'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign pkt_count_d = pkt_count_q +
      ((m_outbuf_axis_tvalid && m_outbuf_axis_tready && m_outbuf_axis_tlast) ? 32'd1 : 32'd0);
  assign pkt_count   = pkt_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  axis_skid_reg #(
    .DATA_WIDTH (BUF_DATA_WIDTH),
    .KEEP_WIDTH (BUF_KEEP_WIDTH),
    .ID_WIDTH   (IdWidth)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   (sel_data),
    .in_keep   (sel_keep),
    .in_last   (sel_last),
    .in_id     (grant_q),
    .in_valid  (sel_valid),
    .in_ready  (skid_ready),
    .out_data  (m_outbuf_axis_tdata),
    .out_keep  (m_outbuf_axis_tkeep),
    .out_last  (m_outbuf_axis_tlast),
    .out_id    (m_outbuf_axis_tid),
    .out_valid (m_outbuf_axis_tvalid),
    .out_ready (m_outbuf_axis_tready)
  );

endmodule

// File: tb/tb_net_recv_pkt_arbiter.sv
// Self-checking bench for net_recv_pkt_arbiter: 4 ports, 32-bit beats.
// Port p's beat b carries data {p, 16'h0, b} and keep b[3:0].
module tb_net_recv_pkt_arbiter;

  localparam int unsigned NP = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned KW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP*DW-1:0] s_inbuf_axis_tdata;
  logic [NP*KW-1:0] s_inbuf_axis_tkeep;
  logic [NP-1:0]    s_inbuf_axis_tlast;
  logic [NP-1:0]    s_inbuf_axis_tvalid;
  logic [NP-1:0]    s_inbuf_axis_tready;
  logic [DW-1:0]    m_outbuf_axis_tdata;
  logic [KW-1:0]    m_outbuf_axis_tkeep;
  logic             m_outbuf_axis_tlast;
  logic             m_outbuf_axis_tvalid;
  logic             m_outbuf_axis_tready;
  logic [1:0]       m_outbuf_axis_tid;
  logic [31:0]      pkt_count;

  net_recv_pkt_arbiter #(
    .NUM_PORTS      (NP),
    .BUF_DATA_WIDTH (DW),
    .BUF_KEEP_WIDTH (KW)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_inbuf_axis_tdata   (s_inbuf_axis_tdata),
    .s_inbuf_axis_tkeep   (s_inbuf_axis_tkeep),
    .s_inbuf_axis_tlast   (s_inbuf_axis_tlast),
    .s_inbuf_axis_tvalid  (s_inbuf_axis_tvalid),
    .s_inbuf_axis_tready  (s_inbuf_axis_tready),
    .m_outbuf_axis_tdata  (m_outbuf_axis_tdata),
    .m_outbuf_axis_tkeep  (m_outbuf_axis_tkeep),
    .m_outbuf_axis_tlast  (m_outbuf_axis_tlast),
    .m_outbuf_axis_tvalid (m_outbuf_axis_tvalid),
    .m_outbuf_axis_tready (m_outbuf_axis_tready),
    .m_outbuf_axis_tid    (m_outbuf_axis_tid),
    .pkt_count            (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            rst_first;
    logic [3:0]      valid;
    logic [3:0]      last;
    logic [3:0][7:0] beats;
    logic [3:0]      e_sready;
    logic            e_mvalid;
    logic [1:0]      e_tid;
    logic [7:0]      e_beat;
    logic            e_mlast;
    logic [31:0]     e_cnt;
  } vec_t;

  typedef struct {
    logic [1:0]  tid;
    logic        last;
    logic [31:0] data;
    logic [3:0]  keep;
  } cap_t;

  vec_t vecs [21];
  cap_t cap [$];

  int n_checks = 0;
  int n_pass   = 0;
  int full_cycles = 0;
  int ready_viol  = 0;

  logic       pat_en = 1'b0;
  logic [5:0] pat = 6'b101001;  // bit k = tready in pattern cycle k: 1,0,0,1,0,1
  int         pat_idx = 0;

  // Downstream handshakes and skid-full observations, sampled at the edge.
  always @(posedge clk) begin
    if (rst) begin
      if (m_outbuf_axis_tvalid && m_outbuf_axis_tready)
        cap.push_back('{m_outbuf_axis_tid, m_outbuf_axis_tlast, m_outbuf_axis_tdata,
                        m_outbuf_axis_tkeep});
      if (dut.u_skid.skid_valid_q) begin
        full_cycles++;
        if (s_inbuf_axis_tready != '0) ready_viol++;
      end
    end
  end

  function automatic logic [31:0] data_of(input int p, input logic [7:0] b);
    return {8'(p), 16'h0000, b};
  endfunction

  function automatic vec_t mk(input logic rf, input logic [3:0] v, input logic [3:0] l,
                              input logic [31:0] bs, input logic [3:0] sr, input logic mv,
                              input logic [1:0] tid, input logic [7:0] bt, input logic ml,
                              input logic [31:0] cnt);
    vec_t r;
    r.rst_first = rf; r.valid = v; r.last = l; r.beats = bs;
    r.e_sready = sr; r.e_mvalid = mv; r.e_tid = tid; r.e_beat = bt; r.e_mlast = ml;
    r.e_cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    if (pat_en) begin
      m_outbuf_axis_tready = pat[pat_idx];
      pat_idx = (pat_idx == 5) ? 0 : pat_idx + 1;
    end
  endtask

  task automatic set_port(input int p, input logic [7:0] b, input logic l, input logic v);
    s_inbuf_axis_tdata[p*DW +: DW] = data_of(p, b);
    s_inbuf_axis_tkeep[p*KW +: KW] = b[3:0];
    s_inbuf_axis_tlast[p]          = l;
    s_inbuf_axis_tvalid[p]         = v;
  endtask

  // Present one beat and hold it until the arbiter takes it (bounded).
  task automatic send_beat(input int p, input logic [7:0] b, input logic l);
    logic done;
    done = 1'b0;
    set_port(p, b, l, 1'b1);
    for (int n = 0; n < 64 && !done; n++) begin
      if (s_inbuf_axis_tready[p]) done = 1'b1;
      tick();
    end
    s_inbuf_axis_tvalid[p] = 1'b0;
    chk($sformatf("handshake p%0d b%02h", p, b), done, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("reset_state", {m_outbuf_axis_tvalid, m_outbuf_axis_tdata, m_outbuf_axis_tkeep,
                        m_outbuf_axis_tlast, m_outbuf_axis_tid, pkt_count,
                        s_inbuf_axis_tready}, '0);
    s_inbuf_axis_tvalid = '0;
    s_inbuf_axis_tlast  = '0;
    s_inbuf_axis_tdata  = '0;
    s_inbuf_axis_tkeep  = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  function automatic logic [127:0] pack_cap(input cap_t c);
    return {c.tid, c.last, c.keep, c.data};
  endfunction

  function automatic logic [127:0] pack_exp(input int p, input logic l, input logic [7:0] b);
    return {2'(p), l, b[3:0], data_of(p, b)};
  endfunction

  initial begin
    int base;
    logic [127:0] act, exp;

    // Ports 0 and 2 each with a 3-beat packet, then round-robin 1-beat packets on all ports.
    vecs[0]  = mk(1, 4'b0101, 4'b0000, 32'h00210001, 4'b0000, 0, 0, 8'h00, 0, 0);
    vecs[1]  = mk(0, 4'b0101, 4'b0000, 32'h00210001, 4'b0001, 0, 0, 8'h00, 0, 0);
    vecs[2]  = mk(0, 4'b0101, 4'b0000, 32'h00210002, 4'b0001, 1, 0, 8'h01, 0, 0);
    vecs[3]  = mk(0, 4'b0101, 4'b0001, 32'h00210003, 4'b0001, 1, 0, 8'h02, 0, 0);
    vecs[4]  = mk(0, 4'b0100, 4'b0000, 32'h00210000, 4'b0000, 1, 0, 8'h03, 1, 0);
    vecs[5]  = mk(0, 4'b0100, 4'b0000, 32'h00210000, 4'b0100, 0, 0, 8'h00, 0, 1);
    vecs[6]  = mk(0, 4'b0100, 4'b0000, 32'h00220000, 4'b0100, 1, 2, 8'h21, 0, 1);
    vecs[7]  = mk(0, 4'b0100, 4'b0100, 32'h00230000, 4'b0100, 1, 2, 8'h22, 0, 1);
    vecs[8]  = mk(0, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 1, 2, 8'h23, 1, 1);
    vecs[9]  = mk(0, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 0, 0, 8'h00, 0, 2);
    vecs[10] = mk(1, 4'b1111, 4'b1111, 32'h13121110, 4'b0000, 0, 0, 8'h00, 0, 0);
    vecs[11] = mk(0, 4'b1111, 4'b1111, 32'h13121110, 4'b0001, 0, 0, 8'h00, 0, 0);
    vecs[12] = mk(0, 4'b1111, 4'b1111, 32'h13121110, 4'b0000, 1, 0, 8'h10, 1, 0);
    vecs[13] = mk(0, 4'b1111, 4'b1111, 32'h13121110, 4'b0010, 0, 0, 8'h00, 0, 1);
    vecs[14] = mk(0, 4'b1111, 4'b1111, 32'h13121110, 4'b0000, 1, 1, 8'h11, 1, 1);
    vecs[15] = mk(0, 4'b1111, 4'b1111, 32'h13121110, 4'b0100, 0, 0, 8'h00, 0, 2);
    vecs[16] = mk(0, 4'b1111, 4'b1111, 32'h13121110, 4'b0000, 1, 2, 8'h12, 1, 2);
    vecs[17] = mk(0, 4'b1111, 4'b1111, 32'h13121110, 4'b1000, 0, 0, 8'h00, 0, 3);
    vecs[18] = mk(0, 4'b1111, 4'b1111, 32'h13121110, 4'b0000, 1, 3, 8'h13, 1, 3);
    vecs[19] = mk(0, 4'b1111, 4'b1111, 32'h13121110, 4'b0001, 0, 0, 8'h00, 0, 4);
    vecs[20] = mk(0, 4'b1111, 4'b1111, 32'h13121110, 4'b0000, 1, 0, 8'h10, 1, 4);

    rst = 1'b0;
    m_outbuf_axis_tready = 1'b1;
    s_inbuf_axis_tvalid = '0;
    s_inbuf_axis_tlast  = '0;
    s_inbuf_axis_tdata  = '0;
    s_inbuf_axis_tkeep  = '0;
    tick();

    for (int i = 0; i < 21; i++) begin
      if (vecs[i].rst_first) do_reset();
      m_outbuf_axis_tready = 1'b1;
      for (int p = 0; p < 4; p++)
        set_port(p, vecs[i].beats[p], vecs[i].last[p], vecs[i].valid[p]);
      act = {s_inbuf_axis_tready, m_outbuf_axis_tvalid, pkt_count};
      exp = {vecs[i].e_sready, vecs[i].e_mvalid, vecs[i].e_cnt};
      if (vecs[i].e_mvalid) begin
        act = {act[36:0], m_outbuf_axis_tid, m_outbuf_axis_tlast, m_outbuf_axis_tkeep,
               m_outbuf_axis_tdata};
        exp = {exp[36:0], vecs[i].e_tid, vecs[i].e_mlast, vecs[i].e_beat[3:0],
               data_of(int'(vecs[i].e_tid), vecs[i].e_beat)};
      end
      chk($sformatf("vec[%0d]", i), act, exp);
      tick();
    end

    // Lock held on port 1 across a 5-cycle valid gap while port 3 waits.
    do_reset();
    base = cap.size();
    set_port(3, 8'h3D, 1'b1, 1'b1);
    send_beat(1, 8'h0A, 1'b0);
    send_beat(1, 8'h0B, 1'b0);
    for (int n = 0; n < 5; n++) tick();
    send_beat(1, 8'h0C, 1'b1);
    send_beat(3, 8'h3D, 1'b1);
    for (int n = 0; n < 4; n++) tick();
    chk("gap_count", 128'(cap.size() - base), 128'd4);
    if (cap.size() >= base + 4) begin
      chk("gap_beat_a", pack_cap(cap[base]),     pack_exp(1, 1'b0, 8'h0A));
      chk("gap_beat_b", pack_cap(cap[base + 1]), pack_exp(1, 1'b0, 8'h0B));
      chk("gap_beat_c", pack_cap(cap[base + 2]), pack_exp(1, 1'b1, 8'h0C));
      chk("gap_port3",  pack_cap(cap[base + 3]), pack_exp(3, 1'b1, 8'h3D));
    end

    // 16-beat packet against a 1,0,0,1,0,1 downstream ready pattern.
    do_reset();
    base = cap.size();
    pat_idx = 0;
    pat_en  = 1'b1;
    for (int b = 0; b < 16; b++) send_beat(0, 8'(b), b == 15);
    for (int n = 0; n < 200 && cap.size() < base + 16; n++) tick();
    for (int n = 0; n < 6; n++) tick();
    pat_en = 1'b0;
    m_outbuf_axis_tready = 1'b1;
    chk("bp_count", 128'(cap.size() - base), 128'd16);
    for (int b = 0; b < 16; b++) begin
      if (base + b < cap.size())
        chk($sformatf("bp_beat[%0d]", b), pack_cap(cap[base + b]), pack_exp(0, b == 15, 8'(b)));
    end
    chk("bp_skid_filled", 128'(full_cycles > 0), 128'd1);
    chk("bp_ready_when_full", 128'(ready_viol), 128'd0);
    chk("bp_pkt_count", pkt_count, 32'd1);

    // Reset mid-packet on port 3, then port 0 must win with no residue.
    do_reset();
    send_beat(3, 8'h30, 1'b0);
    send_beat(3, 8'h31, 1'b0);
    chk("pre_rst_valid", m_outbuf_axis_tvalid, 1'b1);
    do_reset();
    base = cap.size();
    set_port(3, 8'h32, 1'b0, 1'b1);
    send_beat(0, 8'h40, 1'b1);
    s_inbuf_axis_tvalid = '0;
    for (int n = 0; n < 5; n++) tick();
    chk("rst_count", 128'(cap.size() - base), 128'd1);
    if (cap.size() > base)
      chk("rst_port0_first", pack_cap(cap[base]), pack_exp(0, 1'b1, 8'h40));

    // Counter wrap from all-ones.
    force dut.pkt_count_q = 32'hFFFF_FFFF;
    tick();
    release dut.pkt_count_q;
    tick();
    chk("wrap_preload", pkt_count, 32'hFFFF_FFFF);
    send_beat(1, 8'h55, 1'b1);
    for (int n = 0; n < 3; n++) tick();
    chk("wrap_count", pkt_count, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/net_recv_pkt_arbiter.md
NET_RECV_PKT_ARBITER -- requirements
Module: net_recv_pkt_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4, is the number of requester packet streams (1..16).
REQ-002 Parameter BUF_DATA_WIDTH, default 512, is the beat data width.
REQ-003 Parameter BUF_KEEP_WIDTH, default 64, is the byte-enable width (BUF_DATA_WIDTH/8).
REQ-004 Port clk  input  1  is the single clock; one clock, and all logic is on its rising edge.
REQ-005 Port rst  input  1  is the reset: asynchronous assert, active-low.
REQ-006 Port s_inbuf_axis_tdata  input  NUM_PORTS*BUF_DATA_WIDTH  carries requester data; port i uses slice i.
REQ-007 Port s_inbuf_axis_tkeep  input  NUM_PORTS*BUF_KEEP_WIDTH  carries requester byte enables.
REQ-008 Port s_inbuf_axis_tlast  input  NUM_PORTS  marks the last beat per requester.
REQ-009 Port s_inbuf_axis_tvalid  input  NUM_PORTS  carries per-requester valid.
REQ-010 Port s_inbuf_axis_tready  output  NUM_PORTS  carries per-requester ready.
REQ-011 Ports m_outbuf_axis_tdata/tkeep/tlast/tvalid  output  BUF_DATA_WIDTH/BUF_KEEP_WIDTH/1/1  form the merged stream to the NET_RECV handler.
REQ-012 Port m_outbuf_axis_tready  input  1  is downstream ready.
REQ-013 Port m_outbuf_axis_tid  output  max(1,$clog2(NUM_PORTS))  gives the source port of the current output beat.
REQ-014 Port pkt_count  output  32  counts packets fully forwarded (tlast beats accepted downstream) and wraps at 2^32.

Function
REQ-015 The FSM SHALL have two states: IDLE and LOCKED.
REQ-016 IDLE: all s_inbuf_axis_tready SHALL be 0; if any tvalid is set, grant SHALL be the first set tvalid searching from rr_ptr upward, modulo NUM_PORTS, and the next state SHALL be LOCKED.
REQ-017 LOCKED: only s_inbuf_axis_tready[grant] SHALL be driven, equal to the skid-buffer-not-full flag; all other readies SHALL be 0.
REQ-018 LOCKED: accepting a beat with tlast=1 SHALL set rr_ptr to (grant+1) mod NUM_PORTS, with NUM_PORTS-1 wrapping to 0, and the next state SHALL be IDLE.
REQ-019 Grant SHALL be held for the whole packet; tvalid[grant] dropping mid-packet SHALL NOT release the lock or switch ports.
REQ-020 A single-beat packet (tlast on the first beat) SHALL release the lock in the same cycle its beat is accepted.
REQ-021 An accepted beat SHALL appear on m_outbuf_axis at the next cycle (latency 1), with unchanged tdata/tkeep/tlast and tid=grant.
REQ-022 The output path SHALL be a 2-entry skid register: s ready depends only on registered state, and no beat is lost or duplicated under arbitrary m_outbuf_axis_tready toggling.
REQ-023 Output beat order SHALL equal acceptance order, and packets SHALL never interleave on the output.
REQ-024 pkt_count SHALL increment by 1 on each cycle where m_outbuf_axis_tvalid, tready and tlast are all 1.
REQ-025 Minimum arbitration overhead SHALL be one IDLE cycle per packet; no other bubbles are permitted while downstream is ready.
REQ-026 With NUM_PORTS=1, the block SHALL behave as a registered pass-through, apart from the one IDLE cycle per packet.

Reset
REQ-027 rst low SHALL immediately force state=IDLE, rr_ptr=0, grant=0, skid entries empty, m_outbuf_axis_tvalid=0, tdata/tkeep/tlast/tid=0, pkt_count=0, and all s ready=0.
REQ-028 Reset mid-packet SHALL discard the partial packet; after release, arbitration SHALL restart from port 0 with no residual beats emitted.
REQ-029 Deassertion of rst SHALL be synchronised to clk externally; the block SHALL NOT sample inputs during the reset-release cycle.

Structure
REQ-030 A shared package SHALL hold the arbiter state enum (IDLE, LOCKED) and the default widths 512/64.
REQ-031 The skid register SHALL be a separate sub-module, axis_skid_reg, parameterised by data, keep and id widths.
REQ-032 The round-robin search SHALL be a function within the module, not a sub-module.

Verification
REQ-033 Ports 0 and 2 each present a 3-beat packet at once, rr_ptr=0, downstream always ready -> output is port0 beats at cycles 2-4, IDLE at 5, port2 beats at 6-8; tid 0 then 2; pkt_count=2.
REQ-034 All 4 ports continuously offer 1-beat packets -> grant order 0,1,2,3,0 (wrap); one output beat every 2 cycles.
REQ-035 Port 1 sends beats 0xA,0xB, drops tvalid for 5 cycles, then sends 0xC with tlast while port 3 is valid throughout -> output is A,B,C with tid=1, and no port-3 beat before C.
REQ-036 Downstream tready pattern 1,0,0,1,0,1... during a 16-beat packet -> all 16 beats delivered in order, none duplicated, and s ready never high when the skid buffer is full.
REQ-037 rst asserted after beat 2 of a 4-beat packet on port 3 -> outputs zero immediately; after release a new port-0 packet is granted first and no port-3 residue is emitted.
REQ-038 pkt_count preloaded via force to 0xFFFFFFFF, then one packet forwarded -> pkt_count=0.
